// File: rtl/ui_cmd_deser.sv
// ui_cmd_deser: synchronizes an async serial clock/data/select interface, shifts bytes MSB-first and buffers them in a small FIFO.
module ui_cmd_deser #(
    parameter int SYNC_STAGES = 2,
    parameter int FIFO_DEPTH  = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ena,
    input  logic       sclk_in,
    input  logic       sdata_in,
    input  logic       csn_in,
    output logic [7:0] byte_data,
    output logic       byte_valid,
    input  logic       byte_ready,
    output logic       busy,
    output logic       frame_err,
    output logic       overflow
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] SHIFT = 1'b1;

    logic [SYNC_STAGES-1:0] sclk_sync_q, sdata_sync_q, csn_sync_q;
    logic                   sclk_prev_q, csn_prev_q;
    logic [0:0]             state_q, state_d;
    logic [2:0]             cnt_q, cnt_d;
    logic [7:0]             shift_q, shift_d;
    logic                   frame_err_q, frame_err_d;
    logic                   overflow_q, overflow_d;
    logic [7:0]             mem_q [FIFO_DEPTH];
    logic [AW-1:0]          wr_q, rd_q;
    logic [AW:0]            count_q;
    logic                   sclk_s, sdata_s, csn_s, sclk_rise, csn_fall;
    logic                   push_req, full, pop, push;

    assign sclk_s     = sclk_sync_q[SYNC_STAGES-1];
    assign sdata_s    = sdata_sync_q[SYNC_STAGES-1];
    assign csn_s      = csn_sync_q[SYNC_STAGES-1];
    assign sclk_rise  = sclk_s & ~sclk_prev_q;
    assign csn_fall   = ~csn_s & csn_prev_q;
    assign byte_valid = count_q != '0;
    assign byte_data  = byte_valid ? mem_q[rd_q] : 8'h00;
    assign busy       = state_q == SHIFT;
    assign frame_err  = frame_err_q;
    assign overflow   = overflow_q;
    assign full       = count_q == (AW+1)'(FIFO_DEPTH);
    assign pop        = byte_valid & byte_ready;
    // A full FIFO still accepts the completing byte when the head leaves on the same edge.
    assign push       = push_req & (~full | pop);
    assign overflow_d = overflow_q | (push_req & full & ~pop);

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        shift_d     = shift_q;
        frame_err_d = 1'b0;
        push_req    = 1'b0;
        if (state_q == IDLE) begin
            if (csn_fall && ena) begin
                state_d = SHIFT;
                cnt_d   = 3'd0;
                shift_d = 8'h00;
            end
        end else if (!ena) begin
            state_d = IDLE;
            cnt_d   = 3'd0;
            shift_d = 8'h00;
        end else if (csn_s) begin
            state_d     = IDLE;
            cnt_d       = 3'd0;
            shift_d     = 8'h00;
            frame_err_d = cnt_q != 3'd0;
        end else if (sclk_rise) begin
            shift_d  = {shift_q[6:0], sdata_s};
            cnt_d    = cnt_q + 3'd1;
            push_req = cnt_q == 3'd7;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sclk_sync_q  <= '0;
            sdata_sync_q <= '0;
            csn_sync_q   <= '1;
            sclk_prev_q  <= 1'b0;
            csn_prev_q   <= 1'b1;
            state_q      <= IDLE;
            cnt_q        <= 3'd0;
            shift_q      <= 8'h00;
            frame_err_q  <= 1'b0;
            overflow_q   <= 1'b0;
            wr_q         <= '0;
            rd_q         <= '0;
            count_q      <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= 8'h00;
        end else begin
            sclk_sync_q  <= {sclk_sync_q[SYNC_STAGES-2:0], sclk_in};
            sdata_sync_q <= {sdata_sync_q[SYNC_STAGES-2:0], sdata_in};
            csn_sync_q   <= {csn_sync_q[SYNC_STAGES-2:0], csn_in};
            sclk_prev_q  <= sclk_s;
            csn_prev_q   <= csn_s;
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            shift_q      <= shift_d;
            frame_err_q  <= frame_err_d;
            overflow_q   <= overflow_d;
            if (push) begin
                mem_q[wr_q] <= shift_d;
                wr_q        <= wr_q + AW'(1);
            end
            if (pop) rd_q <= rd_q + AW'(1);
            count_q <= count_q + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
        end
    end
endmodule

// File: tb/tb_ui_cmd_deser.sv
// tb_ui_cmd_deser: table vectors, directed corner sequences and a randomized queue-model check for ui_cmd_deser.
module tb_ui_cmd_deser;
    localparam int S = 2;
    localparam int D = 2;

    logic       clk = 1'b0, rst = 1'b1, ena = 1'b0, sclk = 1'b0, sdata = 1'b0, csn = 1'b1, ready = 1'b0;
    logic [7:0] byte_data;
    logic       byte_valid, busy, frame_err, overflow;
    int         total = 0, bad = 0, fe_cnt = 0, v_cnt = 0, fe0 = 0, v0 = 0;
    logic [7:0] last_data = 8'h00;
    logic [7:0] got [$];
    logic [7:0] mq [$];

    typedef struct {
        logic [7:0] val;
        int         nbits;
        logic       exp_valid;
        int         exp_err;
    } vec_t;

    ui_cmd_deser #(.SYNC_STAGES(S), .FIFO_DEPTH(D)) dut (
        .clk(clk), .rst(rst), .ena(ena), .sclk_in(sclk), .sdata_in(sdata), .csn_in(csn),
        .byte_data(byte_data), .byte_valid(byte_valid), .byte_ready(ready),
        .busy(busy), .frame_err(frame_err), .overflow(overflow)
    );

    always #5 clk = ~clk;

    // Sampled on the rising edge so the pre-edge output values are counted.
    always @(posedge clk) begin
        if (frame_err) fe_cnt++;
        if (byte_valid) begin
            v_cnt++;
            last_data = byte_data;
        end
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1);
    end

    task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
        total++;
        if (a !== e) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", n, a, e);
        end
    endtask

    task automatic wait_n(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic start_frame();
        sclk = 1'b0;
        csn  = 1'b0;
        wait_n(S + 3);
    endtask

    task automatic end_frame();
        sclk = 1'b0;
        csn  = 1'b1;
        wait_n(S + 4);
    endtask

    task automatic send_bit(input logic b);
        sdata = b;
        sclk  = 1'b0;
        wait_n(4);
        sclk  = 1'b1;
        wait_n(4);
    endtask

    task automatic send_bits(input logic [7:0] v, input int n);
        for (int i = 0; i < n; i++) send_bit(v[7-i]);
    endtask

    task automatic drain();
        got.delete();
        for (int k = 0; k < 12; k++) begin
            if (!byte_valid) break;
            got.push_back(byte_data);
            ready = 1'b1;
            @(negedge clk);
        end
        ready = 1'b0;
    endtask

    task automatic cmp_q(input string n, input logic [7:0] e [$]);
        chk({n, "_count"}, got.size(), e.size());
        for (int i = 0; i < e.size() && i < got.size(); i++) chk({n, "_byte"}, got[i], e[i]);
    endtask

    task automatic pulse_rst();
        csn  = 1'b1;
        sclk = 1'b0;
        rst  = 1'b1;
        wait_n(2);
        rst  = 1'b0;
        wait_n(S + 4);
    endtask

    initial begin
        vec_t tbl [6];
        logic [7:0] e [$];
        logic [7:0] v;
        int nb, part, fe_exp;
        logic ovf;
        tbl = '{'{8'hA5, 8, 1'b1, 0}, '{8'h5A, 5, 1'b0, 1}, '{8'hFF, 8, 1'b1, 0},
                '{8'h00, 8, 1'b1, 0}, '{8'h81, 3, 1'b0, 1}, '{8'h7E, 0, 1'b0, 0}};
        #1;
        chk("rst_valid", byte_valid, 1'b0);
        chk("rst_data", byte_data, 8'h00);
        chk("rst_busy", busy, 1'b0);
        chk("rst_ferr", frame_err, 1'b0);
        chk("rst_ovf", overflow, 1'b0);
        wait_n(2);
        rst = 1'b0;
        ena = 1'b1;
        wait_n(S + 4);

        for (int i = 0; i < 6; i++) begin
            fe0 = fe_cnt;
            start_frame();
            send_bits(tbl[i].val, tbl[i].nbits);
            end_frame();
            chk("tbl_valid", byte_valid, tbl[i].exp_valid);
            if (tbl[i].exp_valid) chk("tbl_data", byte_data, tbl[i].val);
            chk("tbl_ferr", fe_cnt - fe0, tbl[i].exp_err);
            drain();
            e.delete();
            if (tbl[i].exp_valid) e.push_back(tbl[i].val);
            cmp_q("tbl_drain", e);
        end

        ready = 1'b1;
        v0 = v_cnt;
        fe0 = fe_cnt;
        start_frame();
        send_bits(8'hA5, 8);
        end_frame();
        ready = 1'b0;
        chk("a5_valid_cycles", v_cnt - v0, 1);
        chk("a5_data", last_data, 8'hA5);
        chk("a5_ferr", fe_cnt - fe0, 0);
        chk("a5_ovf", overflow, 1'b0);

        start_frame();
        send_bits(8'h3C, 8);
        chk("b2b_busy", busy, 1'b1);
        send_bits(8'hC3, 8);
        end_frame();
        chk("b2b_head", byte_data, 8'h3C);
        ready = 1'b1;
        @(negedge clk);
        ready = 1'b0;
        chk("b2b_valid", byte_valid, 1'b1);
        chk("b2b_second", byte_data, 8'hC3);
        drain();
        e = '{8'hC3};
        cmp_q("b2b_drain", e);

        // Third byte completes on the very edge the head is popped.
        start_frame();
        send_bits(8'h11, 8);
        send_bits(8'h22, 8);
        send_bits(8'h33, 7);
        sdata = 1'b1;
        sclk  = 1'b0;
        wait_n(4);
        sclk  = 1'b1;
        wait_n(S);
        ready = 1'b1;
        wait_n(1);
        ready = 1'b0;
        wait_n(3);
        end_frame();
        chk("popsame_ovf", overflow, 1'b0);
        chk("popsame_head", byte_data, 8'h22);
        drain();
        e = '{8'h22, 8'h33};
        cmp_q("popsame_drain", e);

        start_frame();
        send_bits(8'h11, 8);
        send_bits(8'h22, 8);
        send_bits(8'h33, 8);
        end_frame();
        chk("ovf_set", overflow, 1'b1);
        ena = 1'b0;
        drain();
        e = '{8'h11, 8'h22};
        cmp_q("ovf_drain", e);
        ena = 1'b1;
        wait_n(20);
        chk("ovf_sticky", overflow, 1'b1);

        fe0 = fe_cnt;
        start_frame();
        send_bits(8'hB8, 5);
        end_frame();
        chk("abort_ferr", fe_cnt - fe0, 1);
        chk("abort_valid", byte_valid, 1'b0);
        start_frame();
        send_bits(8'h5A, 8);
        end_frame();
        chk("after_abort_data", byte_data, 8'h5A);
        chk("after_abort_ferr", fe_cnt - fe0, 1);
        drain();
        e = '{8'h5A};
        cmp_q("after_abort_drain", e);

        fe0 = fe_cnt;
        start_frame();
        send_bits(8'h77, 8);
        send_bits(8'hF0, 4);
        chk("mid_busy", busy, 1'b1);
        rst = 1'b1;
        #1;
        chk("mid_rst_valid", byte_valid, 1'b0);
        chk("mid_rst_data", byte_data, 8'h00);
        chk("mid_rst_busy", busy, 1'b0);
        chk("mid_rst_ovf", overflow, 1'b0);
        csn  = 1'b1;
        sclk = 1'b0;
        wait_n(2);
        rst = 1'b0;
        wait_n(S + 4);
        chk("mid_rst_ferr", fe_cnt - fe0, 0);
        send_bits(8'hFF, 8);
        chk("idle_sclk_valid", byte_valid, 1'b0);
        chk("idle_sclk_busy", busy, 1'b0);
        start_frame();
        send_bits(8'hAA, 3);
        ena = 1'b0;
        wait_n(2);
        chk("ena_off_busy", busy, 1'b0);
        send_bits(8'h55, 5);
        end_frame();
        chk("ena_off_valid", byte_valid, 1'b0);
        chk("ena_off_ferr", fe_cnt - fe0, 0);
        chk("ena_off_ovf", overflow, 1'b0);
        ena = 1'b1;

        pulse_rst();
        mq.delete();
        ovf = 1'b0;
        fe_exp = 0;
        fe0 = fe_cnt;
        for (int it = 0; it < 15; it++) begin
            nb   = $urandom_range(0, 3);
            part = $urandom_range(0, 7);
            start_frame();
            for (int b = 0; b < nb; b++) begin
                v = 8'($urandom);
                send_bits(v, 8);
                if (mq.size() < D) mq.push_back(v);
                else ovf = 1'b1;
            end
            v = 8'($urandom);
            send_bits(v, part);
            end_frame();
            if (part != 0) fe_exp++;
            chk("rnd_valid", byte_valid, mq.size() != 0);
            chk("rnd_ovf", overflow, ovf);
            chk("rnd_ferr", fe_cnt - fe0, fe_exp);
            if ($urandom_range(0, 1) == 1) begin
                drain();
                cmp_q("rnd_drain", mq);
                mq.delete();
            end
        end
        drain();
        cmp_q("rnd_final", mq);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/ui_cmd_deser.md
UI_CMD_DESER -- requirements
Module: ui_cmd_deser

Interface
REQ-001 Parameter SYNC_STAGES, default 2, is the synchronizer flop count per serial input pin (legal 2..3).
REQ-002 Parameter FIFO_DEPTH, default 2, is the number of completed-byte entries buffered (power of two, 2..4).
REQ-003 clk  input  1  single system clock, all state on rising edge.
REQ-004 rst  input  1  reset, asynchronous assert, active-high, synchronous deassert handled externally.
REQ-005 ena  input  1  design-selected enable; low = serial capture disabled.
REQ-006 sclk_in  input  1  asynchronous serial clock pin (from ui_in[0]).
REQ-007 sdata_in  input  1  asynchronous serial data pin (from ui_in[1]), MSB first.
REQ-008 csn_in  input  1  asynchronous frame select pin (from ui_in[2]), active-low.
REQ-009 byte_data  output  8  head-of-FIFO byte, valid only while byte_valid=1.
REQ-010 byte_valid  output  1  FIFO non-empty.
REQ-011 byte_ready  input  1  consumer accepts head byte when byte_valid&byte_ready on a clk edge.
REQ-012 busy  output  1  frame active (synchronized csn low and ena high).
REQ-013 frame_err  output  1  one-cycle pulse on aborted partial byte.
REQ-014 overflow  output  1  sticky: a completed byte was dropped.

Function
REQ-015 Each pin SHALL pass through SYNC_STAGES flops; reset values sclk=0, sdata=0, csn=1.
REQ-016 One extra registered copy of synchronized sclk SHALL form a rising-edge detect (sync=1, prev=0).
REQ-017 FSM states: IDLE (csn high or ena low), SHIFT (csn low and ena high); reset state IDLE.
REQ-018 IDLE->SHIFT on synchronized csn falling with ena=1: bit counter and shift register cleared to 0.
REQ-019 In SHIFT, each sclk rising-edge detect SHALL shift synchronized sdata into bit 0 and increment the 3-bit counter.
REQ-020 The 8th sample SHALL complete the byte: written into FIFO on that same clk edge, counter wraps to 0, FSM stays SHIFT for the next byte.
REQ-021 Latency: pin sclk rising edge to sample = SYNC_STAGES+1 clk cycles; completing sample to byte_valid=1 (FIFO empty) = 1 clk cycle.
REQ-022 SHIFT->IDLE on csn rising; if counter!=0, frame_err SHALL pulse high for exactly 1 cycle and partial bits SHALL be discarded.
REQ-023 SHIFT->IDLE on ena falling; counter cleared, no frame_err, no byte written.
REQ-024 sclk edges in IDLE SHALL be ignored.
REQ-025 FIFO: circular, read/write pointers wrap modulo FIFO_DEPTH, count width clog2(FIFO_DEPTH)+1.
REQ-026 byte_data SHALL be the oldest entry; pop on byte_valid&byte_ready.
REQ-027 Byte completes with FIFO full and no pop that cycle: byte dropped, FIFO unchanged, overflow set to 1.
REQ-028 Byte completes with FIFO full and pop same cycle: pop and push both performed, count unchanged, overflow not set.
REQ-029 Byte completes with FIFO empty: push only; byte_valid rises next cycle (no same-cycle bypass).
REQ-030 byte_ready while byte_valid=0 SHALL have no effect.
REQ-031 FIFO SHALL keep draining while ena=0.
REQ-032 overflow SHALL clear only on rst.

Reset
REQ-033 rst=1 SHALL immediately force: FSM IDLE, counter 0, shift register 0, FIFO empty, byte_valid 0, byte_data 0, busy 0, frame_err 0, overflow 0, synchronizers to REQ-015 values.
REQ-034 rst asserted mid-frame SHALL discard the partial byte and buffered bytes without frame_err; after release a new csn falling edge is required before capture.

Verification
REQ-035 csn low, send 0xA5 MSB first, byte_ready=1 -> byte_data=0xA5, byte_valid high 1 cycle, frame_err=0, overflow=0.
REQ-036 Back-to-back 0x3C,0xC3 in one frame, byte_ready=0 -> FIFO holds both, byte_data=0x3C then 0xC3 after one pop.
REQ-037 byte_ready=0, send 0x11,0x22,0x33 -> overflow=1, FIFO drains 0x11,0x22 only; overflow stays 1 until rst.
REQ-038 FIFO full, third byte completes on same cycle as pop -> no overflow, drain order 0x22,0x33 after first pop.
REQ-039 csn raised after 5 bits -> frame_err single-cycle pulse, no byte written; next full frame 0x5A received correctly.
REQ-040 rst pulsed after 4 bits, then ena=0 during a frame -> all outputs at reset values, no byte, no frame_err; sclk in IDLE ignored.
